cfg_cmd_exec: RTL and testbench

Command executor sitting directly downstream of the configuration UART frame receiver. Consumes each 24-bit frame (`frm_rdy`/`cfg_data`), acknowledges it with `clr_frm_rdy`, and executes one of four commands:

- register write
- register read
- timed fire pulse
- status read

It then returns a 16-bit response through `snd_rsp`/`rsp_data` for transmission back to the host. Its register bank drives the rest of the design's configuration inputs.

---
 rtl/cfg_cmd_exec.sv | 130 +++++++++++++
 tb/tb_cfg_cmd_exec.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cfg_cmd_exec.sv
// Configuration command executor: consumes 24-bit frames, runs WRITE/READ/FIRE/STATUS,
// returns a 16-bit response and drives the configuration register bank and fire pulse.
module cfg_cmd_exec #(
    parameter logic [15:0] ACK_VAL  = 16'hA5A5,
    parameter logic [15:0] NAK_VAL  = 16'hEEEE,
    parameter logic [15:0] BUSY_VAL = 16'hBBBB
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         frm_rdy_i,
    input  logic [23:0]  cfg_data_i,
    output logic         clr_frm_rdy_o,
    output logic         snd_rsp_o,
    output logic [15:0]  rsp_data_o,
    output logic [127:0] cfg_regs_o,
    output logic         fire_o,
    output logic         busy_o
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    localparam logic [3:0] OpWrite  = 4'h1;
    localparam logic [3:0] OpRead   = 4'h2;
    localparam logic [3:0] OpFire   = 4'h3;
    localparam logic [3:0] OpStatus = 4'h4;

    state_e            state_q, state_d;
    logic [23:0]       cmd_q, cmd_d;
    logic [7:0][15:0]  regs_q, regs_d;
    logic [15:0]       rsp_q, rsp_d;
    logic [11:0]       cnt_q, cnt_d;
    logic [15:0]       fire_cnt_q, fire_cnt_d;

    logic [3:0]  cmd_op;
    logic [2:0]  cmd_idx;
    logic        addr_ok;
    logic [15:0] cmd_data;

    assign cmd_op   = cmd_q[23:20];
    assign addr_ok  = ~cmd_q[19];
    assign cmd_idx  = cmd_q[18:16];
    assign cmd_data = cmd_q[15:0];

    assign cfg_regs_o = regs_q;
    assign rsp_data_o = rsp_q;
    assign fire_o     = (fire_cnt_q != 16'd0);
    assign busy_o     = (state_q != StIdle);

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        regs_d        = regs_q;
        rsp_d         = rsp_q;
        cnt_d         = cnt_q;
        // Pulse counter free-runs so commands keep flowing during a pulse.
        fire_cnt_d    = fire_o ? fire_cnt_q - 16'd1 : 16'd0;
        clr_frm_rdy_o = 1'b0;
        snd_rsp_o     = 1'b0;

        case (state_q)
            StIdle: begin
                if (frm_rdy_i) begin
                    clr_frm_rdy_o = 1'b1;
                    cmd_d         = cfg_data_i;
                    state_d       = StExec;
                end
            end
            StExec: begin
                state_d = StResp;
                case (cmd_op)
                    OpWrite: begin
                        if (addr_ok) begin
                            regs_d[cmd_idx] = cmd_data;
                            rsp_d           = ACK_VAL;
                            cnt_d           = cnt_q + 12'd1;
                        end else begin
                            rsp_d = NAK_VAL;
                        end
                    end
                    OpRead: begin
                        if (addr_ok) begin
                            rsp_d = regs_q[cmd_idx];
                            cnt_d = cnt_q + 12'd1;
                        end else begin
                            rsp_d = NAK_VAL;
                        end
                    end
                    OpFire: begin
                        if (fire_o) begin
                            rsp_d = BUSY_VAL;
                        end else begin
                            fire_cnt_d = cmd_data;
                            rsp_d      = ACK_VAL;
                            cnt_d      = cnt_q + 12'd1;
                        end
                    end
                    OpStatus: begin
                        rsp_d = {fire_o, 3'b000, cnt_q};
                        cnt_d = cnt_q + 12'd1;
                    end
                    default: rsp_d = NAK_VAL;
                endcase
            end
            StResp: begin
                snd_rsp_o = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cmd_q      <= '0;
            regs_q     <= '0;
            rsp_q      <= '0;
            cnt_q      <= '0;
            fire_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            regs_q     <= regs_d;
            rsp_q      <= rsp_d;
            cnt_q      <= cnt_d;
            fire_cnt_q <= fire_cnt_d;
        end
    end

endmodule

// File: tb/tb_cfg_cmd_exec.sv
// Directed bench for cfg_cmd_exec: frame handshake timing, commands, fire pulse,
// reset mid-command, counter wrap and back-to-back frames.
module tb_cfg_cmd_exec;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         frm_rdy;
    logic [23:0]  cfg_data;
    logic         clr_frm_rdy;
    logic         snd_rsp;
    logic [15:0]  rsp_data;
    logic [127:0] cfg_regs;
    logic         fire;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;
    int fire_hi = 0;
    int snd_cnt = 0;
    int clr_cnt = 0;

    cfg_cmd_exec dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frm_rdy_i     (frm_rdy),
        .cfg_data_i    (cfg_data),
        .clr_frm_rdy_o (clr_frm_rdy),
        .snd_rsp_o     (snd_rsp),
        .rsp_data_o    (rsp_data),
        .cfg_regs_o    (cfg_regs),
        .fire_o        (fire),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    // Event counters sampled mid-low-phase, after inputs have settled.
    always begin
        @(negedge clk);
        #2;
        if (fire) fire_hi++;
        if (snd_rsp) snd_cnt++;
        if (clr_frm_rdy) clr_cnt++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one frame starting at the next negedge (cycle N) and checks handshake timing.
    task automatic send(input logic [23:0] f, output logic [15:0] rsp,
                        output logic [127:0] regs_n2, output logic fire_n1,
                        output logic fire_n2);
        @(negedge clk);
        frm_rdy  = 1'b1;
        cfg_data = f;
        #1;
        chk("clr_at_N", clr_frm_rdy, 1);
        chk("busy_at_N", busy, 0);
        @(negedge clk);
        frm_rdy  = 1'b0;
        cfg_data = 24'h0FF0FF;
        #1;
        chk("clr_at_N1", clr_frm_rdy, 0);
        chk("busy_at_N1", busy, 1);
        chk("snd_at_N1", snd_rsp, 0);
        fire_n1 = fire;
        @(negedge clk);
        #1;
        chk("snd_at_N2", snd_rsp, 1);
        chk("busy_at_N2", busy, 1);
        rsp     = rsp_data;
        regs_n2 = cfg_regs;
        fire_n2 = fire;
        @(negedge clk);
        #1;
        chk("snd_at_N3", snd_rsp, 0);
        chk("busy_at_N3", busy, 0);
    endtask

    logic [15:0]  r;
    logic [127:0] rg;
    logic         f1, f2;
    int           base;
    logic [15:0]  b2b_exp [4];
    logic [23:0]  b2b_frm [4];

    initial begin
        rst_n    = 1'b0;
        frm_rdy  = 1'b0;
        cfg_data = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rsp", rsp_data, 0);
        chk("rst_regs", cfg_regs, 0);
        chk("rst_outs", {clr_frm_rdy, snd_rsp, fire, busy}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_outs", {clr_frm_rdy, snd_rsp, fire, busy}, 0);

        // Write then read-back of register 3.
        send(24'h131234, r, rg, f1, f2);
        chk("wr_rsp", r, 16'hA5A5);
        chk("wr_regs_N2", rg, 128'h1234 << 48);
        send(24'h230000, r, rg, f1, f2);
        chk("rd_rsp", r, 16'h1234);

        // Illegal address / opcode: NAK, no side effects.
        send(24'h191111, r, rg, f1, f2);
        chk("nak_wr_rsp", r, 16'hEEEE);
        send(24'h2A0000, r, rg, f1, f2);
        chk("nak_rd_rsp", r, 16'hEEEE);
        send(24'h700000, r, rg, f1, f2);
        chk("nak_op_rsp", r, 16'hEEEE);
        chk("nak_regs", cfg_regs, 128'h1234 << 48);
        send(24'h400000, r, rg, f1, f2);
        chk("status_cnt2", r, 16'h0002);

        // Fire 5 cycles, BUSY during the pulse, then a zero-length fire.
        base = fire_hi;
        send(24'h300005, r, rg, f1, f2);
        chk("fire5_rsp", r, 16'hA5A5);
        chk("fire5_N1_low", f1, 0);
        chk("fire5_N2_high", f2, 1);
        send(24'h300009, r, rg, f1, f2);
        chk("fire_busy_rsp", r, 16'hBBBB);
        repeat (12) @(negedge clk);
        #3;
        chk("fire5_len", fire_hi - base, 5);
        chk("fire_idle", fire, 0);
        base = fire_hi;
        send(24'h300000, r, rg, f1, f2);
        chk("fire0_rsp", r, 16'hA5A5);
        repeat (5) @(negedge clk);
        #3;
        chk("fire0_len", fire_hi - base, 0);

        // Reset asserted mid-EXEC of a write while a long pulse is running.
        send(24'h300050, r, rg, f1, f2);
        chk("fire80_rsp", r, 16'hA5A5);
        @(negedge clk);
        frm_rdy  = 1'b1;
        cfg_data = 24'h155555;
        @(negedge clk);
        frm_rdy  = 1'b0;
        #1;
        chk("pre_rst_busy", busy, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_outs", {clr_frm_rdy, snd_rsp, fire, busy}, 0);
        chk("midrst_rsp", rsp_data, 0);
        chk("midrst_regs", cfg_regs, 0);
        base = snd_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #3;
        chk("midrst_no_snd", snd_cnt - base, 0);
        chk("midrst_regs_after", cfg_regs, 0);
        chk("midrst_fire_after", fire, 0);

        // 4096 valid writes wrap the command counter back to zero.
        for (int i = 0; i < 4096; i++) begin
            logic [15:0] iv;
            iv = 16'(i);
            send({5'b00010, iv[2:0], iv}, r, rg, f1, f2);
            chk("bulk_wr_rsp", r, 16'hA5A5);
        end
        send(24'h400000, r, rg, f1, f2);
        chk("status_wrap", r, 16'h0000);
        send(24'h300064, r, rg, f1, f2);
        chk("fire100_rsp", r, 16'hA5A5);
        send(24'h170001, r, rg, f1, f2);
        chk("wr7_rsp", r, 16'hA5A5);
        send(24'h400000, r, rg, f1, f2);
        chk("status_fire", r, 16'h8003);

        // Back-to-back: frm_rdy held high, next frame presented after each snd_rsp.
        b2b_frm[0] = 24'h10AAAA; b2b_exp[0] = 16'hA5A5;
        b2b_frm[1] = 24'h200000; b2b_exp[1] = 16'hAAAA;
        b2b_frm[2] = 24'h11BBB1; b2b_exp[2] = 16'hA5A5;
        b2b_frm[3] = 24'h210000; b2b_exp[3] = 16'hBBB1;
        base = clr_cnt;
        @(negedge clk);
        frm_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cfg_data = b2b_frm[k];
            #1;
            chk("b2b_clr_N", clr_frm_rdy, 1);
            @(negedge clk);
            #1;
            chk("b2b_clr_N1", clr_frm_rdy, 0);
            @(negedge clk);
            #1;
            chk("b2b_snd_N2", snd_rsp, 1);
            chk("b2b_clr_N2", clr_frm_rdy, 0);
            chk("b2b_rsp", rsp_data, b2b_exp[k]);
            @(negedge clk);
        end
        frm_rdy = 1'b0;
        #3;
        chk("b2b_clr_total", clr_cnt - base, 4);
        repeat (3) @(negedge clk);
        #1;
        chk("b2b_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
